// File: rtl/vga_sync_porch_if.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_porch_if
//  Description : Bundles the pixel stream of vga_sync_porch. The upstream
//                side carries active-region HSync/VSync and RGB video. The
//                downstream side carries active-low VGA syncs, blanked video,
//                recovered counts, lock and sticky timing-error status.
//                  slave  : the porch block (reads i_*, drives o_*)
//                  master : the pixel source / board side (drives i_*)
//  Revision    : 1.0  initial release
// ============================================================================
interface vga_sync_porch_if #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525
);
  logic                          i_HSync;
  logic                          i_VSync;
  logic [VIDEO_WIDTH-1:0]        i_Red_Video;
  logic [VIDEO_WIDTH-1:0]        i_Grn_Video;
  logic [VIDEO_WIDTH-1:0]        i_Blu_Video;
  logic                          o_HSync;
  logic                          o_VSync;
  logic [VIDEO_WIDTH-1:0]        o_Red_Video;
  logic [VIDEO_WIDTH-1:0]        o_Grn_Video;
  logic [VIDEO_WIDTH-1:0]        o_Blu_Video;
  logic [$clog2(TOTAL_COLS)-1:0] o_Col_Count;
  logic [$clog2(TOTAL_ROWS)-1:0] o_Row_Count;
  logic                          o_Locked;
  logic                          o_Sync_Err;

  modport slave (
    input  i_HSync, i_VSync, i_Red_Video, i_Grn_Video, i_Blu_Video,
    output o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
           o_Col_Count, o_Row_Count, o_Locked, o_Sync_Err
  );

  modport master (
    output i_HSync, i_VSync, i_Red_Video, i_Grn_Video, i_Blu_Video,
    input  o_HSync, o_VSync, o_Red_Video, o_Grn_Video, o_Blu_Video,
           o_Col_Count, o_Row_Count, o_Locked, o_Sync_Err
  );
endinterface
`default_nettype wire

// File: rtl/vga_sync_porch.sv
`default_nettype none
// ============================================================================
//  Module      : vga_sync_porch
//  Description : Converts the active-region HSync/VSync of the upstream sync
//                generator into standard active-low VGA sync pulses placed
//                after the front porches, and blanks video outside the
//                visible area. Column/row counts are recovered from the
//                VSync rising edge. Two-stage pipeline: inputs -> outputs
//                in 2 clocks.
//  Ports       : i_Clk  pixel clock
//                i_Rst  asynchronous active-high reset
//                vga    vga_sync_porch_if.slave
//                       in : i_HSync, i_VSync, i_{Red,Grn,Blu}_Video
//                       out: o_HSync, o_VSync (active low),
//                            o_{Red,Grn,Blu}_Video (blanked),
//                            o_Col_Count, o_Row_Count, o_Locked, o_Sync_Err
//  Options     : VGA_SYNC_PORCH_ERR_CHECK_EN - when defined, o_Sync_Err
//                flags a frame start that arrives while locked and not at
//                the last pixel of the frame (sticky until reset). When
//                undefined, o_Sync_Err is tied low.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_sync_porch #(
  parameter int VIDEO_WIDTH   = 3,
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 18,
  parameter int H_BACK_PORCH  = 50,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33
) (
  input  wire logic       i_Clk,
  input  wire logic       i_Rst,
  vga_sync_porch_if.slave vga
);

  localparam int CW = $clog2(TOTAL_COLS);
  localparam int RW = $clog2(TOTAL_ROWS);

  localparam logic [CW-1:0] c_COL_LAST  = CW'(TOTAL_COLS - 1);
  localparam logic [RW-1:0] c_ROW_LAST  = RW'(TOTAL_ROWS - 1);
  localparam logic [CW-1:0] c_ACT_COLS  = CW'(ACTIVE_COLS);
  localparam logic [RW-1:0] c_ACT_ROWS  = RW'(ACTIVE_ROWS);
  localparam logic [CW-1:0] c_HS_START  = CW'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CW-1:0] c_HS_END    = CW'(TOTAL_COLS - H_BACK_PORCH);
  localparam logic [RW-1:0] c_VS_START  = RW'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [RW-1:0] c_VS_END    = RW'(TOTAL_ROWS - V_BACK_PORCH);

  // --------------------------------------------------------------------------
  // Stage 1: registered pixel, recovered counts, lock
  // --------------------------------------------------------------------------
  logic                   vs_prev_q;
  logic [VIDEO_WIDTH-1:0] red1_q, grn1_q, blu1_q;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic                   seen_q;
  logic                   w_frame_start;

  // Previous-VSync resets high so a VSync already asserted when reset
  // releases is not mistaken for a frame start.
  assign w_frame_start = vga.i_VSync & ~vs_prev_q;

  // Frame start has priority so a mid-frame VSync edge resynchronises at once.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (w_frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (col_q == c_COL_LAST) begin
      col_d = '0;
      if (row_q == c_ROW_LAST) begin
        row_d = '0;
      end else begin
        row_d = row_q + RW'(1);
      end
    end else begin
      col_d = col_q + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      vs_prev_q <= 1'b1;
      red1_q    <= '0;
      grn1_q    <= '0;
      blu1_q    <= '0;
      col_q     <= '0;
      row_q     <= '0;
      seen_q    <= 1'b0;
    end else begin
      vs_prev_q <= vga.i_VSync;
      red1_q    <= vga.i_Red_Video;
      grn1_q    <= vga.i_Grn_Video;
      blu1_q    <= vga.i_Blu_Video;
      col_q     <= col_d;
      row_q     <= row_d;
      if (w_frame_start) begin
        seen_q <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 2: sync placement, blanking, registered outputs
  // --------------------------------------------------------------------------
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
  logic [CW-1:0]          ocol_q;
  logic [RW-1:0]          orow_q;
  logic                   lock_q;
  logic                   w_visible;

  // Until the first frame start has been seen the counts are meaningless,
  // so syncs are held inactive and video is forced dark.
  always_comb begin
    w_visible = seen_q && (col_q < c_ACT_COLS) && (row_q < c_ACT_ROWS);
    hs_d  = ~(seen_q && (col_q >= c_HS_START) && (col_q < c_HS_END));
    vs_d  = ~(seen_q && (row_q >= c_VS_START) && (row_q < c_VS_END));
    red_d = '0;
    grn_d = '0;
    blu_d = '0;
    if (w_visible) begin
      red_d = red1_q;
      grn_d = grn1_q;
      blu_d = blu1_q;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      red_q  <= '0;
      grn_q  <= '0;
      blu_q  <= '0;
      ocol_q <= '0;
      orow_q <= '0;
      lock_q <= 1'b0;
    end else begin
      hs_q   <= hs_d;
      vs_q   <= vs_d;
      red_q  <= red_d;
      grn_q  <= grn_d;
      blu_q  <= blu_d;
      ocol_q <= col_q;
      orow_q <= row_q;
      lock_q <= seen_q;
    end
  end

  assign vga.o_HSync     = hs_q;
  assign vga.o_VSync     = vs_q;
  assign vga.o_Red_Video = red_q;
  assign vga.o_Grn_Video = grn_q;
  assign vga.o_Blu_Video = blu_q;
  assign vga.o_Col_Count = ocol_q;
  assign vga.o_Row_Count = orow_q;
  assign vga.o_Locked    = lock_q;

  // --------------------------------------------------------------------------
  // Optional frame-timing check
  // --------------------------------------------------------------------------
`ifdef VGA_SYNC_PORCH_ERR_CHECK_EN
  logic err_q;
  logic w_err_set;

  // A clean frame start lands exactly when stage 1 holds the last pixel.
  assign w_err_set = w_frame_start & lock_q &
                     ~((col_q == c_COL_LAST) && (row_q == c_ROW_LAST));

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      err_q <= 1'b0;
    end else if (w_err_set) begin
      err_q <= 1'b1;
    end
  end

  assign vga.o_Sync_Err = err_q;
`else
  assign vga.o_Sync_Err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_sync_porch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_sync_porch
//  Description : Self-checking bench for vga_sync_porch using a reduced
//                timing (20 x 13 total, 12 x 8 active). A frame-position
//                model checks every output each cycle; directed literal
//                checks pin sync windows, blanking edges, lock, resync,
//                mid-frame reset and frame period.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_sync_porch;

  localparam int VW  = 3;
  localparam int TC  = 20;
  localparam int TR  = 13;
  localparam int AC  = 12;
  localparam int AR  = 8;
  localparam int HFP = 2;
  localparam int HBP = 3;
  localparam int VFP = 1;
  localparam int VBP = 2;
  localparam int FR  = TC * TR;   // 260 clocks per frame

`ifdef VGA_SYNC_PORCH_ERR_CHECK_EN
  localparam int c_ERR_EXP = 1;
`else
  localparam int c_ERR_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cmp_en = 1'b0;

  always #5 clk = ~clk;

  vga_sync_porch_if #(.VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR)) vif ();

  vga_sync_porch #(
    .VIDEO_WIDTH(VW), .TOTAL_COLS(TC), .TOTAL_ROWS(TR),
    .ACTIVE_COLS(AC), .ACTIVE_ROWS(AR),
    .H_FRONT_PORCH(HFP), .H_BACK_PORCH(HBP),
    .V_FRONT_PORCH(VFP), .V_BACK_PORCH(VBP)
  ) dut (
    .i_Clk(clk),
    .i_Rst(rst),
    .vga  (vif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: position in frame = clocks since the last VSync rising edge.
  // --------------------------------------------------------------------------
  int n = 0, last_fs = 0;
  bit prev_vs = 1'b1;
  int s_col = 0, s_row = 0, s_r = 0, s_g = 0, s_b = 0;
  bit s_seen = 1'b0;
  int e_col = 0, e_row = 0, e_r = 0, e_g = 0, e_b = 0;
  bit e_hs = 1'b1, e_vs = 1'b1, e_lock = 1'b0, e_err = 1'b0;

  task automatic model_reset();
    n = 0; last_fs = 0; prev_vs = 1'b1;
    s_col = 0; s_row = 0; s_r = 0; s_g = 0; s_b = 0; s_seen = 1'b0;
    e_col = 0; e_row = 0; e_r = 0; e_g = 0; e_b = 0;
    e_hs = 1'b1; e_vs = 1'b1; e_lock = 1'b0; e_err = 1'b0;
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset();
      end else begin
        bit in_vs, fs, vis;
        int in_r, in_g, in_b, k;
        in_vs = vif.i_VSync;
        in_r  = int'(vif.i_Red_Video);
        in_g  = int'(vif.i_Grn_Video);
        in_b  = int'(vif.i_Blu_Video);
        fs    = in_vs && !prev_vs;
        if (c_ERR_EXP == 1 && fs && e_lock && ((n - last_fs) % FR) != FR - 1)
          e_err = 1'b1;
        vis    = s_seen && s_col < AC && s_row < AR;
        e_col  = s_col;
        e_row  = s_row;
        e_lock = s_seen;
        e_hs   = !(s_seen && s_col >= AC + HFP && s_col < TC - HBP);
        e_vs   = !(s_seen && s_row >= AR + VFP && s_row < TR - VBP);
        e_r    = vis ? s_r : 0;
        e_g    = vis ? s_g : 0;
        e_b    = vis ? s_b : 0;
        n++;
        prev_vs = in_vs;
        if (fs) begin
          last_fs = n;
          s_seen  = 1'b1;
        end
        k     = n - last_fs;
        s_col = k % TC;
        s_row = (k / TC) % TR;
        s_r = in_r; s_g = in_g; s_b = in_b;
      end
    end
  end

  // Compare every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        checks++;
        if (vif.o_HSync !== e_hs || vif.o_VSync !== e_vs ||
            int'(vif.o_Red_Video) != e_r || int'(vif.o_Grn_Video) != e_g ||
            int'(vif.o_Blu_Video) != e_b || int'(vif.o_Col_Count) != e_col ||
            int'(vif.o_Row_Count) != e_row || vif.o_Locked !== e_lock ||
            vif.o_Sync_Err !== e_err) begin
          errors++;
          $display("FAIL model_cmp t=%0t: got hs=%0b vs=%0b rgb=%0d/%0d/%0d col=%0d row=%0d lock=%0b err=%0b expected hs=%0b vs=%0b rgb=%0d/%0d/%0d col=%0d row=%0d lock=%0b err=%0b",
                   $time, vif.o_HSync, vif.o_VSync, vif.o_Red_Video, vif.o_Grn_Video,
                   vif.o_Blu_Video, vif.o_Col_Count, vif.o_Row_Count, vif.o_Locked,
                   vif.o_Sync_Err, e_hs, e_vs, e_r, e_g, e_b, e_col, e_row, e_lock, e_err);
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Upstream generator
  // --------------------------------------------------------------------------
  int ucol = 0, urow = 3, ufr = 0;
  int drv_col = 0, drv_row = 0, drv_fr = 0;
  int vis_col = 0, vis_row = 0, vis_fr = 0;
  int cyc = 0;

  // Drives one pixel, then returns 1 ns after the edge that samples it.
  // On return the outputs carry the pixel driven by the previous call.
  task automatic drive_cycle();
    bit white, inject;
    white  = (ufr == 2);
    inject = (ufr == 3 && ucol == 9 && urow == 5);
    vis_col = drv_col; vis_row = drv_row; vis_fr = drv_fr;
    drv_col = ucol;    drv_row = urow;    drv_fr = ufr;
    vif.i_HSync = (ucol < AC);
    vif.i_VSync = (urow < AR) && !inject;
    if (white) begin
      vif.i_Red_Video = 3'd7; vif.i_Grn_Video = 3'd7; vif.i_Blu_Video = 3'd7;
    end else begin
      vif.i_Red_Video = 3'(ucol + urow);
      vif.i_Grn_Video = 3'(ucol);
      vif.i_Blu_Video = 3'(urow + 3);
    end
    if (ucol == AC - 1 && urow == AR - 1) begin
      vif.i_Red_Video = 3'b101; vif.i_Grn_Video = 3'b101; vif.i_Blu_Video = 3'b101;
    end else if (ucol == AC && urow == AR - 1) begin
      vif.i_Red_Video = 3'b111; vif.i_Grn_Video = 3'b111; vif.i_Blu_Video = 3'b111;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (ucol == TC - 1) begin
      ucol = 0;
      if (urow == TR - 1) begin
        urow = 0;
        ufr++;
      end else begin
        urow++;
      end
    end else begin
      ucol++;
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_hsync"}, int'(vif.o_HSync), 1);
    chk({tag, "_vsync"}, int'(vif.o_VSync), 1);
    chk({tag, "_video"}, int'({vif.o_Red_Video, vif.o_Grn_Video, vif.o_Blu_Video}), 0);
    chk({tag, "_col"},   int'(vif.o_Col_Count), 0);
    chk({tag, "_row"},   int'(vif.o_Row_Count), 0);
    chk({tag, "_lock"},  int'(vif.o_Locked), 0);
    chk({tag, "_err"},   int'(vif.o_Sync_Err), 0);
  endtask

  int nz_vid = 0, hs_low = 0, vs_low = 0;
  int fall_cnt = 0, last_fall = 0;
  bit prev_ovs = 1'b1;
  bit did_rst = 1'b0;
  int guard = 0;

  initial begin
    vif.i_HSync = 1'b0; vif.i_VSync = 1'b0;
    vif.i_Red_Video = '0; vif.i_Grn_Video = '0; vif.i_Blu_Video = '0;
    #2 rst = 1'b1;
    #1 cmp_en = 1'b1;
    chk_reset_values("por");
    // Upstream runs from row 3 with VSync already high: not a frame start.
    repeat (3) drive_cycle();
    chk_reset_values("in_reset");
    rst = 1'b0;

    while (ufr < 8 && guard < 20 * FR) begin
      guard++;
      if (ufr == 4 && ucol == 8 && urow == 6 && !did_rst) begin
        did_rst = 1'b1;
        rst = 1'b1;
        #1;
        chk_reset_values("midframe_rst");
        drive_cycle();
        rst = 1'b0;
      end
      drive_cycle();

      // Before the first frame start: syncs idle, video dark.
      if (vis_fr == 0 && vis_col == 15 && vis_row == 3) begin
        chk("prelock_hsync", int'(vif.o_HSync), 1);
        chk("prelock_lock", int'(vif.o_Locked), 0);
      end
      if (vis_fr == 0 && vis_col == 5 && vis_row == 4)
        chk("prelock_video", int'(vif.o_Red_Video), 0);

      if ((vis_fr == 1 || vis_fr == 5) && vis_col == 0 && vis_row == 0) begin
        chk("first_pix_lock", int'(vif.o_Locked), 1);
        chk("first_pix_col", int'(vif.o_Col_Count), 0);
        chk("first_pix_row", int'(vif.o_Row_Count), 0);
      end

      if (vis_fr == 1 && vis_row == 0) begin
        if (vis_col == 13) chk("hs_col13", int'(vif.o_HSync), 1);
        if (vis_col == 14) chk("hs_col14", int'(vif.o_HSync), 0);
        if (vis_col == 16) chk("hs_col16", int'(vif.o_HSync), 0);
        if (vis_col == 17) chk("hs_col17", int'(vif.o_HSync), 1);
      end
      if (vis_fr == 1 && vis_col == 0) begin
        if (vis_row == 8)  chk("vs_row8", int'(vif.o_VSync), 1);
        if (vis_row == 9)  chk("vs_row9", int'(vif.o_VSync), 0);
        if (vis_row == 10) chk("vs_row10", int'(vif.o_VSync), 0);
        if (vis_row == 11) chk("vs_row11", int'(vif.o_VSync), 1);
      end
      if (vis_fr == 1 && vis_row == 7 && vis_col == 11) begin
        chk("last_active_red", int'(vif.o_Red_Video), 5);
        chk("last_active_col", int'(vif.o_Col_Count), 11);
        chk("last_active_row", int'(vif.o_Row_Count), 7);
      end
      if (vis_fr == 1 && vis_row == 7 && vis_col == 12) begin
        chk("first_blank_red", int'(vif.o_Red_Video), 0);
        chk("first_blank_col", int'(vif.o_Col_Count), 12);
        chk("first_blank_row", int'(vif.o_Row_Count), 7);
      end

      if (vis_fr == 2) begin
        if ({vif.o_Red_Video, vif.o_Grn_Video, vif.o_Blu_Video} != '0) nz_vid++;
        if (vif.o_HSync == 1'b0) hs_low++;
        if (vif.o_VSync == 1'b0) vs_low++;
      end

      if (vis_fr == 3 && vis_col == 10 && vis_row == 5) begin
        chk("resync_col", int'(vif.o_Col_Count), 0);
        chk("resync_row", int'(vif.o_Row_Count), 0);
        chk("resync_err", int'(vif.o_Sync_Err), c_ERR_EXP);
      end

      if (vis_fr == 4 && vis_col == 19 && vis_row == 12 && did_rst)
        chk("post_rst_unlocked", int'(vif.o_Locked), 0);

      if (vis_fr >= 5 && prev_ovs && !vif.o_VSync) begin
        if (fall_cnt > 0) chk("vsync_period", cyc - last_fall, FR);
        fall_cnt++;
        last_fall = cyc;
      end
      prev_ovs = vif.o_VSync;
    end

    chk("run_complete", ufr, 8);
    chk("white_visible_pixels", nz_vid, 96);
    chk("white_hsync_low_clocks", hs_low, 39);
    chk("white_vsync_low_clocks", vs_low, 40);
    chk("vsync_falls_clean", fall_cnt, 3);
    chk("clean_frames_err", int'(vif.o_Sync_Err), 0);
    chk("clean_frames_lock", int'(vif.o_Locked), 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
